fast_slow_rate_sampler: RTL and testbench
=========================================

// Module: fast_slow_rate_sampler
// PURPOSE
//  Single-clock rate converter from the fast DDS sample stream to a slow strobe-qualified stream.
//  The fast producer asserts in_valid whenever it has a sample.
//  An internal divider issues one output strobe every 2**DIV_LOG2 clocks.
//  Each strobe delivers the most recent sample, or the window average when the option below is compiled in.
//  Sits between the fast NCO/modulator path and slow-rate consumers (DAC pacing, display, decimated logging).
// PARAMETERS
//  WIDTH     12  sample width, unsigned
//  DIV_LOG2   2  window length DIV = 2**DIV_LOG2 clocks, range 1..4
//  OVR_W      8  width of the saturating overrun counter
// PORTS
//  clk       in   1         single clock; all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  sync_clr  in   1         synchronous window restart; phase-aligns the divider
//  in_valid  in   1         fast-side sample strobe, one sample per asserted cycle
//  in        in   WIDTH     fast-side sample
//  out       out  WIDTH     slow-side sample, held between strobes
//  out_valid out  1         one-cycle pulse; out updated this cycle
//  out_fresh out  1         1 = at least one in_valid in the window that produced out
//  ovr_cnt   out  OVR_W     count of windows with >1 in_valid; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0): cnt=0, hold=0, acc=0, seen=0, multi=0; out=0, out_valid=0, out_fresh=0, ovr_cnt=0.
//  Divider: cnt increments every clk and wraps DIV-1 -> 0. Tick cycle = cycle where cnt==DIV-1.
//  Effective sample eff = in_valid ? in : hold. Bypass: a sample arriving on the tick cycle is used.
//  hold <= eff every cycle.
//  seen sets on in_valid; multi sets on in_valid while seen==1. Both clear after the tick.
//  On tick, registered (out_valid high the following cycle):
//    out <= selected value; out_fresh <= seen|in_valid; out_valid <= 1.
//    ovr_cnt += 1 if (>1 in_valid in window incl. tick cycle), saturating at 2**OVR_W-1.
//  Outside the tick cycle: out_valid=0; out and out_fresh hold their values.
//  Latency: in_valid on the tick cycle -> out visible 1 clk later.
//  No in_valid in a window -> out repeats the hold value, out_fresh=0, out_valid still pulses.
//  sync_clr=1: cnt<=0, seen/multi/acc cleared, no tick that cycle even if cnt==DIV-1.
//    out, out_fresh, ovr_cnt and hold are kept; hold still loads if in_valid.
//    The next tick occurs DIV cycles after sync_clr deasserts.
//  rst_n asserted mid-window: everything returns to reset values immediately; the partial window is discarded.
//  Arithmetic: all unsigned; acc width WIDTH+DIV_LOG2, never overflows over DIV cycles.
// CONFIGURATION
//  FS_RATE_AVG_EN defined:
//    acc accumulates eff every cycle (zero-order-hold average).
//    On tick: out <= (acc+eff) >> DIV_LOG2, truncating; acc <= 0.
//  FS_RATE_AVG_EN undefined:
//    acc logic is absent; on tick out <= eff (latest sample).
//  out_fresh and ovr_cnt behave identically in both builds.
// TESTING (WIDTH=12, DIV_LOG2=2, so DIV=4; rst_n released before edge 0; ticks at edges 3,7,11,...)
//  1 Reset then in_valid with in=10 at edge 1 only
//    -> out=10, out_fresh=1, out_valid high for exactly 1 clk after edge 3; ovr_cnt=0.
//  2 No in_valid in the next window
//    -> out=10, out_fresh=0, out_valid pulses after edge 7.
//  3 in=1,5,54 with in_valid at edges 8,9,10
//    -> out=54 after edge 11; ovr_cnt=1; out_fresh=1.
//  4 in=20 with in_valid only at tick edge 15 (bypass)
//    -> out=20 after edge 15; ovr_cnt unchanged.
//  5 sync_clr at edge 17
//    -> no pulse at edge 19; next pulse after edge 21.
//    rst_n low at edge 22 -> out=0, ovr_cnt=0 asynchronously.
//  6 FS_RATE_AVG_EN, held values 0,0,4,4 over one window -> out=2.
//    Constant 4095 over one window -> out=4095 (no overflow).
//    Hold 1 for 3 cycles then 0 -> out=0 (truncation).

Source files
------------

// File: rtl/fast_slow_rate_sampler.sv
// Fast-to-slow rate sampler: one output strobe every 2**DIV_LOG2 clocks. The strobe carries the latest sample,
// or the window average when FS_RATE_AVG_EN is defined. Latency is one clock from the tick; there is no backpressure.
module fast_slow_rate_sampler #(
  parameter int WIDTH    = 12,
  parameter int DIV_LOG2 = 2,
  parameter int OVR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_fresh,
  output logic [OVR_W-1:0] ovr_cnt
);

  logic [DIV_LOG2-1:0] cnt;
  logic [WIDTH-1:0]    hold;
  logic [WIDTH-1:0]    eff;
  logic [WIDTH-1:0]    sel;
  logic                seen;
  logic                multi;
  logic                tick;
  logic                over;

  // A sample arriving on the tick cycle bypasses hold and is used directly.
  assign eff  = in_valid ? in : hold;
  assign tick = (&cnt) && !sync_clr;
  assign over = multi || (seen && in_valid);

`ifdef FS_RATE_AVG_EN
  localparam int ACC_W = WIDTH + DIV_LOG2;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + ACC_W'(eff);
  assign sel     = acc_sum[ACC_W-1:DIV_LOG2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (sync_clr || tick) begin
      acc <= '0;
    end else begin
      acc <= acc_sum;
    end
  end
`else
  assign sel = eff;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hold      <= '0;
      seen      <= 1'b0;
      multi     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      out_fresh <= 1'b0;
      ovr_cnt   <= '0;
    end else begin
      cnt       <= sync_clr ? '0 : cnt + 1'b1;
      hold      <= eff;
      out_valid <= tick;
      if (sync_clr || tick) begin
        seen  <= 1'b0;
        multi <= 1'b0;
      end else if (in_valid) begin
        seen <= 1'b1;
        if (seen) multi <= 1'b1;
      end
      if (tick) begin
        out       <= sel;
        out_fresh <= seen || in_valid;
        if (over && !(&ovr_cnt)) ovr_cnt <= ovr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fast_slow_rate_sampler.sv
// Bench for fast_slow_rate_sampler: directed scenarios plus random traffic, scoreboarded against a window model.
module tb_fast_slow_rate_sampler;
  localparam int WIDTH = 12;
  localparam int DIV_LOG2 = 2;
  localparam int DIV = 1 << DIV_LOG2;
  localparam int OVR_MAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] out;
  logic out_valid;
  logic out_fresh;
  logic [7:0] ovr_cnt;

  fast_slow_rate_sampler #(.WIDTH(WIDTH), .DIV_LOG2(DIV_LOG2), .OVR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid), .in(din),
    .out(out), .out_valid(out_valid), .out_fresh(out_fresh), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int out;
    int fresh;
    int ovr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int edge_cnt;
  int last_out = 0;
  int last_fresh = 0;

  // Reference model state: the samples seen in the current window.
  int win[$];
  int nv = 0;
  int hold_m = 0;
  int ovr_m = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic v, input int d, input logic clr);
    int eff;
    int s;
    exp_t x;
    eff = v ? d : hold_m;
    hold_m = eff;
    if (clr) begin
      win.delete();
      nv = 0;
    end else begin
      win.push_back(eff);
      nv += int'(v);
      if (win.size() == DIV) begin
`ifdef FS_RATE_AVG_EN
        s = 0;
        foreach (win[i]) s += win[i];
        x.out = s / DIV;
`else
        x.out = win[DIV-1];
`endif
        if (nv > 1 && ovr_m < OVR_MAX) ovr_m++;
        x.e = edge_cnt;
        x.fresh = (nv > 0) ? 1 : 0;
        x.ovr = ovr_m;
        sb.push_back(x);
        win.delete();
        nv = 0;
      end
    end
  endtask

  task automatic step(input logic v, input int d, input logic clr);
    in_valid = v;
    din = WIDTH'(d);
    sync_clr = clr;
    model(v, d, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    sync_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_fresh", int'(out_fresh), 0);
    chk("rst_ovr", int'(ovr_cnt), 0);
    win.delete();
    nv = 0;
    hold_m = 0;
    ovr_m = 0;
    sb.delete();
    last_out = 0;
    last_fresh = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops an expected strobe whenever the DUT pulses out_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("pulse_edge", edge_cnt - 1, x.e);
          chk("pulse_out", int'(out), x.out);
          chk("pulse_fresh", int'(out_fresh), x.fresh);
          chk("pulse_ovr", int'(ovr_cnt), x.ovr);
          last_out = x.out;
          last_fresh = x.fresh;
        end
      end else begin
        if (sb.size() > 0 && sb[0].e < edge_cnt - 1) begin
          chk("missed_pulse", 0, 1);
          void'(sb.pop_front());
        end
        chk("held_out", int'(out), last_out);
        chk("held_fresh", int'(out_fresh), last_fresh);
      end
    end
  end

  initial begin
    logic v;
    logic clr;
    int dens;
    #12;
    do_reset();
`ifdef FS_RATE_AVG_EN
    step(1, 0, 0); step(0, 0, 0); step(1, 4, 0); step(0, 0, 0);
    chk("avg_0044", int'(out), 2);
    step(1, 4095, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("avg_full", int'(out), 4095);
    step(1, 1, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
    chk("avg_trunc", int'(out), 0);
    @(negedge clk);
`else
    step(0, 0, 0); step(1, 10, 0); step(0, 0, 0); step(0, 0, 0);
    chk("t1_out", int'(out), 10);
    chk("t1_fresh", int'(out_fresh), 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_ovr", int'(ovr_cnt), 0);
    step(0, 0, 0);
    chk("t1_pulse_len", int'(out_valid), 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("t2_out", int'(out), 10);
    chk("t2_fresh", int'(out_fresh), 0);
    chk("t2_valid", int'(out_valid), 1);
    step(1, 1, 0); step(1, 5, 0); step(1, 54, 0); step(0, 0, 0);
    chk("t3_out", int'(out), 54);
    chk("t3_ovr", int'(ovr_cnt), 1);
    chk("t3_fresh", int'(out_fresh), 1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, 20, 0);
    chk("t4_out", int'(out), 20);
    chk("t4_ovr", int'(ovr_cnt), 1);
    step(0, 0, 0); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    chk("t5_no_pulse", int'(out_valid), 0);
    step(0, 0, 0); step(0, 0, 0);
    chk("t5_pulse", int'(out_valid), 1);
    @(negedge clk);
`endif
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      dens = ((i / 250) % 4) * 30 + 5;
      v = ($urandom_range(0, 99) < dens);
      clr = ($urandom_range(0, 99) < 3);
      step(v, int'($urandom_range(0, 4095)), clr);
      if (i == 800) begin
        @(negedge clk);
        do_reset();
      end
    end
    for (int i = 0; i < 1200; i++) begin
      step(1'b1, int'($urandom_range(0, 4095)), 1'b0);
    end
    step(0, 0, 0);
    @(negedge clk);
    chk("ovr_saturated", int'(ovr_cnt), OVR_MAX);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
